// File: rtl/upg_uart_loader.sv
// UART programming loader: receives a 16-bit word count plus little-endian
// 32-bit words over 8N1 and writes them to consecutive memory word addresses.
module upg_uart_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rstn_i,
  input  logic              upg_rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int REM_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
  typedef enum logic [1:0] {F_HDR0, F_HDR1, F_WORD, F_DONE} frm_state_t;

  logic             rx_meta_q, rx_sync_q;
  bit_state_t       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frm_err;

  frm_state_t       frm_q, frm_d;
  logic [7:0]       cnt_lo_q, cnt_lo_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      buf_q, buf_d;
  logic             wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             err_q, err_d;
  logic [15:0]      hdr_count;

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      bit_q      <= B_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_q      <= F_HDR0;
      cnt_lo_q   <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= upg_rx_i;
      rx_sync_q  <= rx_meta_q;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      frm_q      <= frm_d;
      cnt_lo_q   <= cnt_lo_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
    end
  end

  // Bit FSM. IDLE is only ever entered with the line high, so a low level
  // there is equivalent to a falling edge and also catches back-to-back starts.
  always_comb begin
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frm_err    = 1'b0;
    case (bit_q)
      B_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) bit_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          bit_d     = rx_sync_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bit_d = B_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_vld_d = 1'b1;
            bit_d      = B_IDLE;
          end else begin
            frm_err = 1'b1;
            bit_d   = B_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_BREAK: begin
        if (rx_sync_q) bit_d = B_IDLE;
      end
      default: bit_d = B_IDLE;
    endcase
  end

  // shift_q holds the completed byte while byte_vld_q is high
  assign hdr_count = {shift_q, cnt_lo_q};

  always_comb begin
    frm_d    = frm_q;
    cnt_lo_d = cnt_lo_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    err_d    = err_q | (frm_err && (frm_q != F_DONE));
    case (frm_q)
      F_HDR0: begin
        if (byte_vld_q) begin
          cnt_lo_d = shift_q;
          frm_d    = F_HDR1;
        end
      end
      F_HDR1: begin
        if (byte_vld_q) begin
          if (hdr_count == 16'd0) begin
            frm_d = F_DONE;
          end else if (32'(hdr_count) > (32'd1 << ADDR_W)) begin
            err_d = 1'b1;
            frm_d = F_HDR0;
          end else begin
            frm_d = F_WORD;
            adr_d = '0;
            idx_d = '0;
            rem_d = REM_W'(hdr_count);
          end
        end
      end
      F_WORD: begin
        if (wen_q) begin
          adr_d = adr_q + ADDR_W'(1);
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) frm_d = F_DONE;
        end else if (byte_vld_q) begin
          if (idx_q == 2'd3) begin
            dat_d = {shift_q, buf_q};
            wen_d = 1'b1;
            idx_d = '0;
          end else begin
            buf_d = {shift_q, buf_q[23:8]};
            idx_d = idx_q + 2'd1;
          end
        end
      end
      F_DONE: ;
      default: frm_d = F_HDR0;
    endcase
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (frm_q == F_DONE);
  assign upg_err_o  = err_q;

endmodule

// File: tb/tb_upg_uart_loader.sv
// Bench for upg_uart_loader: directed UART frames, write scoreboard checked by
// a negedge monitor including the exact strobe cycle.
module tb_upg_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx = 1'b1;
  logic          wen, done, err;
  logic [AW-1:0] adr;
  logic [31:0]   dat;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_wen_exp = 0;
  int hdr_done_exp = 0;
  int done_rise = -1;
  logic done_prev = 1'b0;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    int            at;
  } wr_t;
  wr_t sb[$];

  upg_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .upg_clk_i (clk),
    .upg_rstn_i(rstn),
    .upg_rx_i  (rx),
    .upg_wen_o (wen),
    .upg_adr_o (adr),
    .upg_dat_o (dat),
    .upg_done_o(done),
    .upg_err_o (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every strobe must match the next scoreboard entry, cycle included
  always @(negedge clk) begin : mon
    wr_t e;
    if (rstn && wen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h expected no write", adr, dat);
      end else begin
        e = sb.pop_front();
        chk("wr_adr", 64'(adr), 64'(e.adr));
        chk("wr_dat", 64'(dat), 64'(e.dat));
        chk("wr_cycle", 64'(cyc), 64'(e.at));
      end
    end
    if (done && !done_prev) done_rise = cyc;
    done_prev = done;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    hdr_done_exp = cyc + 42;
    send_byte(n[15:8]);
  endtask

  // A byte started at cycle T yields byte_vld at T+41 and the strobe at T+42
  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    last_wen_exp = cyc + 42;
    sb.push_back('{adr: a, dat: w, at: cyc + 42});
    send_byte(w[31:24]);
  endtask

  task automatic do_reset(input string name);
    rstn = 1'b0;
    rx   = 1'b1;
    idle(3);
    chk(name, {15'd0, wen, done, err, adr, dat}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    sb.delete();
    done_rise = -1;
  endtask

  initial begin
    // Two-word frame preceded by an idle-state glitch
    do_reset("rst_outputs");
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    chk("glitch_err", 64'(err), 64'd0);
    send_hdr(16'd2);
    send_word(32'h12345678, 14'd0);
    send_word(32'hDEADBEEF, 14'd1);
    idle(4);
    chk("A_done", 64'(done), 64'd1);
    chk("A_done_cycle", 64'(done_rise), 64'(last_wen_exp + 1));
    chk("A_err", 64'(err), 64'd0);
    chk("A_adr_after", 64'(adr), 64'd2);
    send_byte(8'hAA);
    send_byte(8'h00, 1'b0);
    idle(10);
    chk("A_done_no_err", 64'(err), 64'd0);
    chk("A_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length frame
    do_reset("rst_B");
    send_hdr(16'd0);
    idle(4);
    chk("B_done", 64'(done), 64'd1);
    chk("B_done_cycle", 64'(done_rise), 64'(hdr_done_exp));
    send_byte(8'hAA);
    idle(4);
    chk("B_err", 64'(err), 64'd0);
    chk("B_adr", 64'(adr), 64'd0);

    // Framing error inside a word
    do_reset("rst_D");
    send_hdr(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h99, 1'b0);
    idle(8);
    chk("D_err", 64'(err), 64'd1);
    chk("D_not_done", 64'(done), 64'd0);
    send_byte(8'h33);
    last_wen_exp = cyc + 42;
    sb.push_back('{adr: 14'd0, dat: 32'h44332211, at: cyc + 42});
    send_byte(8'h44);
    idle(4);
    chk("D_done_cycle", 64'(done_rise), 64'(last_wen_exp + 1));
    chk("D_sb_empty", 64'(sb.size()), 64'd0);

    // Oversize count, recovery, then reset mid-word
    do_reset("rst_C");
    send_hdr(16'h4101);
    idle(4);
    chk("C_err", 64'(err), 64'd1);
    chk("C_not_done", 64'(done), 64'd0);
    send_hdr(16'd2);
    send_word(32'hCAFEF00D, 14'd0);
    send_byte(8'h5A);
    rx = 1'b0;
    idle(10);
    chk("F_adr_before", 64'(adr), 64'd1);
    chk("F_dat_before", 64'(dat), 64'hCAFEF00D);
    #3;
    rstn = 1'b0;
    #1;
    chk("F_async_rst", {15'd0, wen, done, err, adr, dat}, 64'd0);
    rx = 1'b1;
    idle(3);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    done_rise = -1;
    send_hdr(16'd1);
    send_word(32'h0BADC0DE, 14'd0);
    idle(4);
    chk("F_done_cycle", 64'(done_rise), 64'(last_wen_exp + 1));
    chk("F_err", 64'(err), 64'd0);
    chk("F_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
